// File: rtl/img_arith_pkg.sv
// Shared definitions for the image arithmetic engine.
//   - Operation codes selected on the op port.
//   - FSM state encoding (plain constants so older tools can consume them).
//   - pixel_op(): width-generic per-pixel arithmetic used by the datapath.
package img_arith_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'b00;
  localparam op_t OP_SUB = 2'b01;
  localparam op_t OP_ABS = 2'b10;
  localparam op_t OP_AVG = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PROC = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  // Widest pixel the helper supports; callers zero-extend into it and
  // truncate the result back to their own width.
  localparam int PIX_W = 32;

  // One extra bit of headroom carries the add overflow and the sub borrow.
  function automatic logic [PIX_W-1:0] pixel_op(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b,
    input op_t              op,
    input logic             sat,
    input int               w
  );
    logic [PIX_W:0] max_v;
    logic [PIX_W:0] sum;
    logic [PIX_W:0] diff;
    logic [PIX_W:0] mag;
    logic [PIX_W:0] r;
    logic           a_lt_b;
    max_v  = ((PIX_W+1)'(1) << w) - (PIX_W+1)'(1);
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    a_lt_b = (a < b);
    mag    = a_lt_b ? ({1'b0, b} - {1'b0, a}) : diff;
    case (op)
      OP_ADD:  r = (sat && (sum > max_v)) ? max_v : (sum & max_v);
      OP_SUB:  r = (sat && a_lt_b) ? '0 : (diff & max_v);
      OP_ABS:  r = mag;
      default: r = sum >> 1;
    endcase
    return PIX_W'(r);
  endfunction

endpackage

// File: rtl/img_arith_engine_sdp_ram.sv
// sdp_ram: simple dual-port block RAM.
//   clk           clock
//   rst           synchronous active-low reset of the read register only
//   we/waddr/wdata synchronous write port
//   re/raddr      read port; rdata updates one cycle after re, holds when re=0
//   rdata         registered read data
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array itself has no reset so it maps onto block RAM; only the
  // output register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/img_arith_engine.sv
// img_arith_engine: buffers one frame of pixel pairs (A, B), applies a
// per-pixel add/sub/absdiff/avg with optional saturation, streams results out
// over valid/ready and keeps them in a result RAM for readback while idle.
//   clk, rst        clock, synchronous active-low reset
//   op, sat_en      operation and saturation, latched at frame start
//   in_valid/in_ready, in_a, in_b     input pixel pair handshake
//   out_valid/out_ready, out_data     result handshake
//   done            one-cycle pulse at frame completion
//   busy            engine is not idle
//   rd_addr/rd_data result RAM readback (1-cycle latency, idle only)
module img_arith_engine
  import img_arith_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op,
  input  logic              sat_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              done,
  output logic              busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] wr_cnt_q,    wr_cnt_d;
  logic [ADDR_W:0]   rd_cnt_q,    rd_cnt_d;   // one extra bit to reach DEPTH
  logic [ADDR_W-1:0] idx1_q,      idx1_d;
  logic              v1_q,        v1_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [ADDR_W-1:0] out_idx_q,   out_idx_d;
  op_t               op_q,        op_d;
  logic              sat_q,       sat_d;

  logic [DATA_W-1:0] ram_a_rdata, ram_b_rdata, pix_res;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept, advance, in_proc, rd_en_ab, res_we;

  assign in_ready = rst && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  assign accept   = in_valid && in_ready;
  assign in_proc  = (state_q == ST_PROC);
  assign advance  = !out_valid_q || out_ready;
  assign rd_en_ab = in_proc && advance && (rd_cnt_q < DEPTH_CNT);
  assign res_we   = in_proc && advance && v1_q;
  assign wr_addr  = (state_q == ST_IDLE) ? '0 : wr_cnt_q;

  assign pix_res  = DATA_W'(pixel_op(PIX_W'(ram_a_rdata), PIX_W'(ram_b_rdata),
                                     op_q, sat_q, DATA_W));

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = (state_q == ST_FIN);
  assign busy      = (state_q != ST_IDLE);

  // NOTE: every next-state signal starts from its held value so no path
  // through the case statement leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    idx1_d      = idx1_q;
    v1_d        = v1_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    op_d        = op_q;
    sat_d       = sat_q;
    case (state_q)
      ST_IDLE: begin
        rd_cnt_d = '0;
        if (accept) begin
          op_d     = op;
          sat_d    = sat_en;
          wr_cnt_d = ADDR_W'(1);
          state_d  = (DEPTH == 1) ? ST_PROC : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (wr_cnt_q == LAST_ADDR) state_d  = ST_PROC;
          else                       wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
      ST_PROC: begin
        if (advance) begin
          // Stage 1 issues the RAM reads; stage 2 takes the data a cycle later.
          if (rd_cnt_q < DEPTH_CNT) begin
            v1_d     = 1'b1;
            idx1_d   = rd_cnt_q[ADDR_W-1:0];
            rd_cnt_d = rd_cnt_q + 1'b1;
          end else begin
            v1_d = 1'b0;
          end
          out_valid_d = v1_q;
          out_data_d  = pix_res;
          out_idx_d   = idx1_q;
        end
        if (out_valid_q && out_ready && (out_idx_q == LAST_ADDR)) state_d = ST_FIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      idx1_q      <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      op_q        <= OP_ADD;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      idx1_q      <= idx1_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      op_q        <= op_d;
      sat_q       <= sat_d;
    end
  end

  sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_a (
    .clk(clk), .rst(rst),
    .we(accept), .waddr(wr_addr), .wdata(in_a),
    .re(rd_en_ab), .raddr(rd_cnt_q[ADDR_W-1:0]), .rdata(ram_a_rdata)
  );

  sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_b (
    .clk(clk), .rst(rst),
    .we(accept), .waddr(wr_addr), .wdata(in_b),
    .re(rd_en_ab), .raddr(rd_cnt_q[ADDR_W-1:0]), .rdata(ram_b_rdata)
  );

  // Readback port only follows rd_addr while idle; otherwise it holds.
  sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_res (
    .clk(clk), .rst(rst),
    .we(res_we), .waddr(idx1_q), .wdata(pix_res),
    .re(state_q == ST_IDLE), .raddr(rd_addr), .rdata(rd_data)
  );

endmodule

// File: tb/tb_img_arith_engine.sv
// Self-checking bench for img_arith_engine with DATA_W=8, DEPTH=4.
// Directed frames from a table, plus backpressure and mid-frame reset cases.
module tb_img_arith_engine;
  import img_arith_pkg::*;

  typedef logic [3:0][7:0] pix4_t;

  typedef struct {
    logic [1:0] op;
    logic       sat;
    pix4_t      a;
    pix4_t      b;
    pix4_t      exp;
    string      name;
  } vec_t;

  logic       clk = 0;
  logic       rst;
  logic [1:0] op;
  logic       sat_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       done, busy;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;

  int total = 0;
  int bad   = 0;

  vec_t vecs[7];

  img_arith_engine #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .op(op), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pix4_t mk(input int p0, input int p1, input int p2, input int p3);
    pix4_t r;
    r[0] = 8'(p0); r[1] = 8'(p1); r[2] = 8'(p2); r[3] = 8'(p3);
    return r;
  endfunction

  // Called at a negedge with the engine idle; returns at the negedge after
  // the last pair was accepted. op/sat_en are scrambled after the first pair.
  task automatic load_frame(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin op = v.op;  sat_en = v.sat;  end
      else        begin op = ~v.op; sat_en = ~v.sat; end
      in_valid = 1'b1;
      in_a = v.a[i];
      in_b = v.b[i];
      #1;
      check({v.name, " in_ready"}, in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Drains one frame with the given out_ready pattern (bit k%7 on cycle k).
  task automatic receive(input vec_t v, input logic [6:0] pat);
    int n = 0;
    int k = 0;
    int first = -1;
    logic held = 1'b0;
    logic [7:0] held_data = '0;
    check({v.name, " in_ready in proc"}, in_ready, 0);
    in_valid = 1'b1;
    in_a = 8'hAA;
    in_b = 8'h55;
    while (n < 4 && k < 200) begin
      if (out_valid && first < 0) first = k;
      if (held) begin
        check({v.name, " held valid"}, out_valid, 1);
        check({v.name, " held data"}, out_data, held_data);
      end
      out_ready = pat[k % 7];
      if (out_valid && out_ready) begin
        check($sformatf("%s out[%0d]", v.name, n), out_data, v.exp[n]);
        check({v.name, " busy"}, busy, 1);
        n++;
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    check({v.name, " handshakes"}, n, 4);
    check({v.name, " first valid latency"}, first, 2);
    check({v.name, " done pulse"}, done, 1);
    check({v.name, " no extra valid"}, out_valid, 0);
    @(negedge clk);
    check({v.name, " done cleared"}, done, 0);
    check({v.name, " idle"}, busy, 0);
  endtask

  task automatic readback(input vec_t v);
    for (int j = 0; j < 4; j++) begin
      rd_addr = 2'(j);
      @(negedge clk);
      check($sformatf("%s rd[%0d]", v.name, j), rd_data, v.exp[j]);
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [6:0] pat);
    load_frame(v);
    receive(v, pat);
    readback(v);
  endtask

  initial begin
    int n;
    int k;
    vecs[0] = '{OP_ADD, 1'b1, mk(10,200,255,0), mk(20,100,1,0),  mk(30,255,255,0), "add_sat"};
    vecs[1] = '{OP_ADD, 1'b0, mk(10,200,255,0), mk(20,100,1,0),  mk(30,44,0,0),    "add_wrap"};
    vecs[2] = '{OP_SUB, 1'b1, mk(5,100,255,3),  mk(10,40,255,4), mk(0,60,0,0),     "sub_sat"};
    vecs[3] = '{OP_SUB, 1'b0, mk(5,100,255,3),  mk(10,40,255,4), mk(251,60,0,255), "sub_wrap"};
    vecs[4] = '{OP_ABS, 1'b0, mk(5,100,255,3),  mk(10,40,255,4), mk(5,60,0,1),     "abs_nosat"};
    vecs[5] = '{OP_ABS, 1'b1, mk(5,100,255,3),  mk(10,40,255,4), mk(5,60,0,1),     "abs_sat"};
    vecs[6] = '{OP_AVG, 1'b1, mk(5,100,255,3),  mk(10,40,255,4), mk(7,70,255,3),   "avg"};

    rst = 1'b0; op = OP_ADD; sat_en = 1'b0;
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd2;
    out_ready = 1'b1; rd_addr = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst in_ready", in_ready, 0);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst out_data", out_data, 0);
      check("rst rd_data", rd_data, 0);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("post-rst in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 7'h7f);

    // Backpressure: out_ready 1,0,0,1,0,1,1 repeating.
    run_vec(vecs[1], 7'b1101001);
    run_vec(vecs[6], 7'b1101001);

    // Reset in the middle of PROC after two results.
    load_frame(vecs[0]);
    out_ready = 1'b1;
    n = 0;
    k = 0;
    while (n < 2 && k < 50) begin
      if (out_valid) begin
        check($sformatf("midrst out[%0d]", n), out_data, vecs[0].exp[n]);
        n++;
      end
      @(negedge clk);
      k++;
    end
    check("midrst handshakes", n, 2);
    rst = 1'b0;
    @(negedge clk);
    check("midrst out_valid", out_valid, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst idle hold", busy, 0);
    run_vec(vecs[3], 7'h7f);
    run_vec(vecs[0], 7'h7f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/img_arith_engine.md
Name: img_arith_engine

Overview:
- Parametrised successor to the two-buffer image-add block: buffers two pixel streams (A, B) of one frame into internal BRAMs.
- Applies a selectable per-pixel operation (add, sub, absdiff, avg) with optional saturation.
- Streams the results out with a valid/ready handshake and stores them in a result BRAM that can be read back once the frame is finished.
- Sits between a pixel source and downstream image consumers.

Parameters:
- DATA_W, 8, pixel width in bits.
- DEPTH, 64, pixels per frame; each BRAM holds DEPTH words.
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- op  in  2  operation: 00 add, 01 sub (a-b), 10 absdiff, 11 avg.
- sat_en  in  1  1 = saturate, 0 = wrap modulo 2^DATA_W.
- in_valid  in  1  pixel pair valid.
- in_ready  out  1  engine accepts a pair.
- in_a  in  DATA_W  source A pixel.
- in_b  in  DATA_W  source B pixel.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  result pixel.
- done  out  1  one-cycle pulse at frame completion.
- busy  out  1  1 in any state other than IDLE.
- rd_addr  in  ADDR_W  result BRAM readback address.
- rd_data  out  DATA_W  result BRAM word; valid 1 cycle after rd_addr.

Behaviour:
- Reset values: in_ready=0 while rst=0; out_valid=0, out_data=0, done=0, busy=0, rd_data=0. All counters are cleared. BRAM contents are not cleared.
- FSM states: IDLE, LOAD, PROC, FIN.
- IDLE:
  - in_ready=1.
  - On in_valid: op and sat_en are latched for the whole frame; the pair is written to address 0; go to LOAD with wr_cnt=1.
  - Readback is allowed in IDLE only. rd_data <= res_ram[rd_addr] each cycle in IDLE; in other states it holds its last value.
- LOAD:
  - in_ready=1; each accepted pair is written at wr_cnt, then wr_cnt increments.
  - The pair accepted at wr_cnt=DEPTH-1 moves the FSM to PROC the next cycle.
  - DEPTH=1: the IDLE accept goes directly to PROC.
- PROC:
  - in_ready=0; in_valid is ignored.
  - Two-stage pipeline with advance = !out_valid || out_ready.
  - Stage 1: on advance, if rd_cnt<DEPTH, read RAM A and RAM B at rd_cnt (1-cycle latency), set v1=1, increment rd_cnt; otherwise v1=0. Read data holds when advance=0.
  - Stage 2: on advance, out_valid<=v1 and out_data<=f(a,b). When v1=1 the result is also written to res_ram at the output index.
  - First out_valid is 2 cycles after entering PROC. Throughput is 1 pixel/cycle while out_ready=1.
  - out_data is stable while out_valid && !out_ready; no drops, no duplicates.
  - After the handshake of output index DEPTH-1, go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Arithmetic:
  - Use a DATA_W+1 intermediate. MAX = 2^DATA_W - 1.
  - add: sat ? min(a+b, MAX) : (a+b) mod 2^DATA_W.
  - sub: sat ? max(a-b, 0) : (a-b) mod 2^DATA_W.
  - absdiff: |a-b|; sat_en is irrelevant.
  - avg: (a+b)>>1, truncating; never overflows.
- op or sat_en changes mid-frame have no effect until the next frame.
- rst=0 in any state: next cycle the FSM is in IDLE, out_valid=0, the pipeline is flushed and pending results are discarded.

Decomposition:
- Package img_arith_pkg:
  - op codes OP_ADD, OP_SUB, OP_ABS, OP_AVG.
  - FSM state encoding.
  - pure function for the pixel op (a, b, op, sat, width-generic).
- Sub-module sdp_ram (simple dual-port, sync write, registered read with read-enable hold, params DATA_W/DEPTH).
- Instantiated three times: RAM A, RAM B, result RAM.

Test Plan (DATA_W=8, DEPTH=4):
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, busy=0; after release in_ready=1.
- Add: a={10,200,255,0}, b={20,100,1,0}.
  - sat_en=1, out_ready=1 -> out {30,255,255,0}; first out_valid 2 cycles after PROC entry; done 1 cycle after the 4th handshake.
  - sat_en=0 -> {30,44,0,0}.
- Sub / absdiff / avg: a={5,100,255,3}, b={10,40,255,4}.
  - sub sat -> {0,60,0,0}; sub wrap -> {251,60,0,255}.
  - absdiff -> {5,60,0,1}; avg -> {7,70,255,3}.
- Backpressure: out_ready pattern 1,0,0,1,0,1,1... -> each out_data held until accepted, exactly 4 handshakes in order, busy=1 until done.
- Reset mid-PROC after 2 outputs -> out_valid=0 and FSM in IDLE next cycle; a following full frame produces correct results.
- Readback after add-sat frame: rd_addr=1 -> rd_data=255 one cycle later; rd_addr=3 -> 0. Changing op during LOAD does not alter that frame's results.
